// File: rtl/upscale_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : upscale_frame_sequencer
//  Description : Fetches one source frame in raster order over a req/valid
//                handshake and emits each pixel as a single-cycle
//                horizontal_sync beat (latency 1) towards the 2x-upscale
//                output writer. Tracks row/column and pulses frame_done.
//  Option      : LINE_BLANK_EN - when defined, inserts BLANK_CYCLES idle
//                cycles (src_req low) after every line except the last.
//  Ports       : clock/reset (sync, active-high), start,
//                src_req/src_addr/src_valid/src_r/src_g/src_b (source side),
//                horizontal_sync/r/g/b (writer side), col/row, busy,
//                frame_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module upscale_frame_sequencer #(
    parameter int WIDTH        = 768,
    parameter int HEIGHT       = 512,
    parameter int ADDR_W       = 20,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              src_req,
    output logic [ADDR_W-1:0] src_addr,
    input  logic              src_valid,
    input  logic [7:0]        src_r,
    input  logic [7:0]        src_g,
    input  logic [7:0]        src_b,
    output logic              horizontal_sync,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic [15:0]       col,
    output logic [15:0]       row,
    output logic              busy,
    output logic              frame_done
);

    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_BLANK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        col_q, col_d;
    logic [15:0]        row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               hsync_q, hsync_d;
    logic [7:0]         r_q, r_d, g_q, g_d, b_q, b_d;
    logic [BLK_W-1:0]   blank_q, blank_d;

    logic last_col, last_row;
    assign last_col = (col_q == 16'(WIDTH - 1));
    assign last_row = (row_q == 16'(HEIGHT - 1));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        hsync_d = 1'b0;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        blank_d = blank_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            S_FETCH: begin
                // src_req is high for the whole state, so valid alone marks a transfer
                if (src_valid) begin
                    hsync_d = 1'b1;
                    r_d     = src_r;
                    g_d     = src_g;
                    b_d     = src_b;
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            addr_d  = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d  = row_q + 16'd1;
                            // raster order makes the linear address a plain counter
                            addr_d = addr_q + 1'b1;
`ifdef LINE_BLANK_EN
                            state_d = S_BLANK;
                            blank_d = BLK_W'(BLANK_CYCLES - 1);
`endif
                        end
                    end else begin
                        col_d  = col_q + 16'd1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_BLANK: begin
                // counts down BLANK_CYCLES-1 .. 0, i.e. BLANK_CYCLES cycles in state
                if (blank_q == '0) begin
                    state_d = S_FETCH;
                end else begin
                    blank_d = blank_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            hsync_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            hsync_q <= hsync_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            blank_q <= blank_d;
        end
    end

    assign src_req         = (state_q == S_FETCH);
    assign src_addr        = addr_q;
    assign horizontal_sync = hsync_q;
    assign r               = r_q;
    assign g               = g_q;
    assign b               = b_q;
    assign col             = col_q;
    assign row             = row_q;
    assign busy            = (state_q != S_IDLE);
    // last beat and DONE are entered on the same edge, so they coincide
    assign frame_done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_upscale_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upscale_frame_sequencer
//  Description : Randomized self-checking bench for upscale_frame_sequencer
//                (WIDTH=4, HEIGHT=2, BLANK_CYCLES=3). A pixel-count based
//                reference model predicts every output cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upscale_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int BC = 3;
`ifdef LINE_BLANK_EN
    localparam int M_BLANK = BC;
`else
    localparam int M_BLANK = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        src_req;
    logic [19:0] src_addr;
    logic        src_valid;
    logic [7:0]  src_r, src_g, src_b;
    logic        horizontal_sync;
    logic [7:0]  r, g, b;
    logic [15:0] col, row;
    logic        busy;
    logic        frame_done;

    upscale_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(20), .BLANK_CYCLES(BC)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .src_req(src_req), .src_addr(src_addr), .src_valid(src_valid),
        .src_r(src_r), .src_g(src_g), .src_b(src_b),
        .horizontal_sync(horizontal_sync), .r(r), .g(g), .b(b),
        .col(col), .row(row), .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame progress expressed as a pixel count k
    // (address = k, col = k mod W, row = k div W).
    int         m_mode;      // 0 idle, 1 frame in progress, 2 done cycle
    int         m_k;
    int         m_gap;       // remaining blank cycles before fetching resumes
    bit         m_pend;      // a beat is due this cycle
    logic [7:0] m_pr, m_pg, m_pb;
    int         m_beats, m_dones;
    int         d_beats, d_dones;

    task automatic step(input bit rst_i, input bit st_i, input bit vld_i);
        bit req_e;
        @(negedge clock);
        req_e = (m_mode == 1) && (m_gap == 0);
        chk_eq("src_req",    32'(src_req),         32'(req_e));
        chk_eq("src_addr",   32'(src_addr),        32'(m_k));
        chk_eq("col",        32'(col),             32'(m_k % W));
        chk_eq("row",        32'(row),             32'(m_k / W));
        chk_eq("busy",       32'(busy),            32'(m_mode != 0));
        chk_eq("frame_done", 32'(frame_done),      32'(m_mode == 2));
        chk_eq("hsync",      32'(horizontal_sync), 32'(m_pend));
        if (m_pend) begin
            chk_eq("r", 32'(r), 32'(m_pr));
            chk_eq("g", 32'(g), 32'(m_pg));
            chk_eq("b", 32'(b), 32'(m_pb));
            m_beats++;
        end
        if (m_mode == 2) m_dones++;
        if (horizontal_sync === 1'b1) d_beats++;
        if (frame_done === 1'b1) d_dones++;

        reset     = rst_i;
        start     = st_i;
        src_valid = vld_i;
        src_r     = 8'($urandom);
        src_g     = 8'($urandom);
        src_b     = 8'($urandom);

        if (rst_i) begin
            m_mode = 0; m_k = 0; m_gap = 0; m_pend = 0;
        end else begin
            m_pend = req_e && vld_i;
            if (m_pend) begin
                m_pr = src_r; m_pg = src_g; m_pb = src_b;
            end
            case (m_mode)
                0: if (st_i) begin m_mode = 1; m_k = 0; end
                1: begin
                    if (m_gap > 0) m_gap--;
                    else if (vld_i) begin
                        m_k++;
                        if (m_k == W * H) begin
                            m_mode = 2; m_k = 0;
                        end else if (m_k % W == 0) begin
                            m_gap = M_BLANK;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic clear_counts();
        m_beats = 0; m_dones = 0; d_beats = 0; d_dones = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; src_valid = 1'b0;
        src_r = '0; src_g = '0; src_b = '0;
        m_mode = 0; m_k = 0; m_gap = 0; m_pend = 0;
        m_pr = '0; m_pg = '0; m_pb = '0;
        clear_counts();

        // reset held 3 cycles, then idle
        repeat (3) step(1, 0, 0);
        repeat (3) step(0, 0, 1);
        chk_eq("reset_r", 32'(r), 32'd0);
        chk_eq("reset_g", 32'(g), 32'd0);
        chk_eq("reset_b", 32'(b), 32'd0);

        // full frame, valid tied high
        clear_counts();
        step(0, 1, 1);
        repeat (15) step(0, 0, 1);
        chk_eq("beats_streaming", 32'(d_beats), 32'(W * H));
        chk_eq("dones_streaming", 32'(d_dones), 32'd1);

        // valid toggling every cycle
        clear_counts();
        for (int i = 0; i < 30; i++) step(0, i == 0, i[0]);
        chk_eq("beats_toggle", 32'(d_beats), 32'(W * H));
        chk_eq("dones_toggle", 32'(d_dones), 32'd1);

        // reset after the 5th beat aborts the frame
        clear_counts();
        step(0, 1, 1);
        for (int i = 0; i < 40 && m_beats < 5; i++) step(0, 0, 1);
        chk_eq("abort_reached5", 32'(m_beats), 32'd5);
        step(1, 0, 1);
        step(1, 0, 1);
        repeat (4) step(0, 0, 1);
        chk_eq("abort_no_done", 32'(d_dones), 32'd0);
        clear_counts();
        step(0, 1, 1);
        repeat (20) step(0, 0, 1);
        chk_eq("beats_after_abort", 32'(d_beats), 32'(W * H));
        chk_eq("dones_after_abort", 32'(d_dones), 32'd1);

        // random start pulses and random source stalls
        clear_counts();
        for (int i = 0; i < 300; i++)
            step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        chk_eq("beats_random", 32'(d_beats), 32'(m_beats));
        chk_eq("dones_random", 32'(d_dones), 32'(m_dones));

        // start held high: frames run back to back
        clear_counts();
        for (int i = 0; i < 60; i++) step(0, 1, 1);
        chk_eq("dones_held", 32'(d_dones), 32'(m_dones));
        chk_eq("held_multi", 32'(m_dones >= 2), 32'd1);
        step(0, 0, 0);
        repeat (40) step(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
